// File: rtl/mult_pkg.sv
// Shared types and constants for the signed add-shift multiplier datapath.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int SHIFT_STEPS   = 8;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOADB,
    OP_CLR,
    OP_SUB,
    OP_ADD,
    OP_SHIFT
  } dp_op_t;

  // Only the highest-priority strobe is executed in a cycle.
  function automatic dp_op_t decode_op(input logic load_b, input logic clr_ld,
                                       input logic sub, input logic add,
                                       input logic shift);
    dp_op_t op;
    if (load_b)      op = OP_LOADB;
    else if (clr_ld) op = OP_CLR;
    else if (sub)    op = OP_SUB;
    else if (add)    op = OP_ADD;
    else if (shift)  op = OP_SHIFT;
    else             op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/add_sub9.sv
// add_sub9: combinational N-bit ripple adder; sub=1 inverts b and injects carry-in.
// Latency: zero cycles (pure combinational); no backpressure.
module add_sub9 #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_x;
  logic [N-1:0] carry;

  assign b_x      = b ^ {N{sub}};
  assign carry[0] = sub;

  // Carry out of the top bit is intentionally not generated: results wrap mod 2^N.
  for (genvar i = 0; i < N - 1; i++) begin : g_carry
    assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
  end

  assign sum = a ^ b_x ^ carry;

endmodule

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: X:A:B register file executing clear/add/sub/shift steps of a signed add-shift multiply.
// Latency: every command completes in one Clk cycle; strobes are always accepted, no backpressure.
// Optional protocol checker and step counter compiled in with MULT_DP_CHECK_EN.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LoadB,
  input  logic             Clr_Ld,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             M,
  output logic             Err
);

  dp_op_t           op;
  logic             x_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_en;
  logic [WIDTH:0]   sum;

  assign op     = decode_op(LoadB, Clr_Ld, Sub, Add, Shift);
  assign sub_en = (op == OP_SUB);

  add_sub9 #(.N(WIDTH + 1)) u_add_sub (
    .a   ({a_q[WIDTH-1], a_q}),
    .b   ({Din[WIDTH-1], Din}),
    .sub (sub_en),
    .sum (sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      case (op)
        OP_LOADB: begin
          b_q <= Din;
          a_q <= '0;
          x_q <= 1'b0;
        end
        OP_CLR: begin
          a_q <= '0;
          x_q <= 1'b0;
        end
        OP_SUB, OP_ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum;
        end
        OP_SHIFT: {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[WIDTH-1:1]};
        default: ;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign M    = b_q[0];

`ifdef MULT_DP_CHECK_EN
  logic [3:0] step_cnt;
  logic       err_q;
  logic       multi_cmd;
  logic       extra_shift;

  assign multi_cmd   = ($countones({Clr_Ld, Add, Sub, Shift}) > 1);
  assign extra_shift = Shift && (step_cnt >= 4'(SHIFT_STEPS));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      step_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (op == OP_LOADB || op == OP_CLR) step_cnt <= '0;
      else if (op == OP_SHIFT && step_cnt != 4'hF) step_cnt <= step_cnt + 4'd1;
      if (multi_cmd || extra_shift) err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Scoreboard bench for multiplier_datapath: stimulus pushes expected X:A:B/Err, a monitor pops and compares.
module tb_multiplier_datapath;

`ifdef MULT_DP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       LoadB, Clr_Ld, Add, Sub, Shift;
  logic [7:0] Din;
  logic [7:0] Aval, Bval;
  logic       X, M, Err;

  always #5 Clk = ~Clk;

  multiplier_datapath #(.WIDTH(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .LoadB   (LoadB),
    .Clr_Ld  (Clr_Ld),
    .Add     (Add),
    .Sub     (Sub),
    .Shift   (Shift),
    .Din     (Din),
    .Aval    (Aval),
    .Bval    (Bval),
    .X       (X),
    .M       (M),
    .Err     (Err)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  sample_now = 1'b0;

  // Reference model state: the architectural X:A:B value and the sticky error.
  logic [7:0] m_a, m_b;
  logic       m_x, m_err;

  task automatic push_exp(input string nm);
    exp_t e;
    e.a = m_a; e.b = m_b; e.x = m_x; e.err = m_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every queued expectation against the live DUT outputs.
  exp_t  mon_e;
  string mon_nm;
  always @(negedge Clk or posedge sample_now) begin
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if (Aval !== mon_e.a || Bval !== mon_e.b || X !== mon_e.x ||
          M !== mon_e.b[0] || Err !== mon_e.err) begin
        errors++;
        $display("FAIL %s: got A=%h B=%h X=%b M=%b Err=%b, expected A=%h B=%h X=%b M=%b Err=%b",
                 mon_nm, Aval, Bval, X, M, Err, mon_e.a, mon_e.b, mon_e.x, mon_e.b[0], mon_e.err);
      end
    end
  end

  // Called at posedge+1; holds the strobes for exactly one rising edge.
  task automatic do_cmd(input logic lb, input logic cl, input logic ad,
                        input logic sb, input logic sh, input logic [7:0] d);
    LoadB = lb; Clr_Ld = cl; Add = ad; Sub = sb; Shift = sh; Din = d;
    @(posedge Clk);
    #1;
    LoadB = 0; Clr_Ld = 0; Add = 0; Sub = 0; Shift = 0;
  endtask

  task automatic load_b(input logic [7:0] d);
    do_cmd(1, 0, 0, 0, 0, d);
    m_b = d; m_a = 8'h00; m_x = 1'b0;
    push_exp("loadb");
  endtask

  // Full signed multiply; expected product from plain signed arithmetic.
  task automatic run_mult(input logic [7:0] s, input string nm);
    int prod;
    logic [16:0] p17;
    prod = $signed(m_b) * $signed(s);
    do_cmd(0, 1, 0, 0, 0, s);
    for (int i = 0; i < 7; i++) begin
      do_cmd(0, 0, 1, 0, 0, s);
      do_cmd(0, 0, 0, 0, 1, s);
    end
    do_cmd(0, 0, 0, 1, 0, s);
    do_cmd(0, 0, 0, 0, 1, s);
    p17 = prod[16:0];
    {m_x, m_a, m_b} = p17;
    push_exp(nm);
  endtask

  // Asserts reset away from any edge and checks the outputs before the next edge.
  task automatic async_reset(input string nm);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_x = 1'b0; m_err = 1'b0;
    #1 push_exp(nm);
    sample_now = 1'b1;
    #1 sample_now = 1'b0;
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb, rs;
    logic signed [16:0] v;
    LoadB = 0; Clr_Ld = 0; Add = 0; Sub = 0; Shift = 0; Din = 8'h00;
    Reset_n = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_x = 1'b0; m_err = 1'b0;
    #1 push_exp("reset_init");
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Build A=0x3C mid-sequence, then reset asynchronously.
    load_b(8'h01);
    do_cmd(0, 1, 0, 0, 0, 8'h3C);
    do_cmd(0, 0, 1, 0, 0, 8'h3C);
    m_a = 8'h3C;
    push_exp("add_3c");
    async_reset("reset_async");

    load_b(8'h07);
    run_mult(8'hFD, "mult_7x-3");
    load_b(8'h80);
    run_mult(8'h80, "mult_-128x-128");
    load_b(8'h03);
    run_mult(8'h02, "mult_3x2");
    run_mult(8'h02, "mult_rerun_6x2");

    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      load_b(rb);
      run_mult(rs, "mult_rand");
    end

    // Add and Shift together: only the add runs.
    async_reset("reset_pre_multi");
    load_b(8'h01);
    do_cmd(0, 0, 1, 0, 1, 8'h05);
    m_a = 8'h05;
    if (CHK) m_err = 1'b1;
    push_exp("add_shift_same_cycle");
    do_cmd(0, 0, 0, 0, 0, 8'h00);
    push_exp("err_sticky_idle");
    async_reset("reset_clear_err");

    // Ninth shift after a complete multiply.
    load_b(8'h05);
    run_mult(8'hFB, "mult_5x-5");
    do_cmd(0, 0, 0, 0, 1, 8'h00);
    v = {m_x, m_a, m_b};
    v = v >>> 1;
    {m_x, m_a, m_b} = v;
    if (CHK) m_err = 1'b1;
    push_exp("ninth_shift");
    do_cmd(0, 1, 0, 0, 0, 8'h00);
    m_a = 8'h00; m_x = 1'b0;
    push_exp("clr_keeps_err");
    async_reset("reset_final");

    repeat (2) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
